sc_trace_buffer: RTL and testbench
==================================

# sc_trace_buffer

Post-trigger trace capture buffer for the single-cycle RISC-V computer. It samples the `pc`/`instr`/`alu`/`mem` tuple retired on every clock and keeps a rolling pre-trigger history. When a PC trigger fires, it captures a fixed number of further entries and then freezes. A host or bench then drains the buffer one 32-bit word at a time over a valid/ready read port.

## Interface
Parameters:
- `DEPTH`, 16: entry capacity; power of two, ≥2.
- `POST_TRIG`, 8: entries captured from the trigger entry onward; 1 ≤ `POST_TRIG` ≤ `DEPTH`.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `clrn` in 1: reset; synchronous, active-low.
- `pc` in 32: retired PC, sampled every edge.
- `instr` in 32: retired instruction.
- `alu` in 32: ALU result.
- `mem` in 32: data-memory read value.
- `arm` in 1: restart capture; level-sampled, acts on every edge where it is high.
- `trig_en` in 1: 1 = trigger on PC match; 0 = trigger on the first ARMED sample.
- `trig_pc` in 32: trigger PC.
- `rd_valid` out 1: read word available.
- `rd_ready` in 1: consumer accepts the word.
- `rd_data` out 32: current read word.
- `rd_last` out 1: high on the last (4th) word of an entry.
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 STOPPED.
- `count` out clog2(DEPTH)+1: entries held.
- `ovf_cnt` out 16: overwritten-entry count (see Configuration).

## Operation
- Reset (`clrn`=0 at an edge): `state`=IDLE, `count`=0, write/read pointers 0, word index 0, post counter 0, `rd_valid`=0, `rd_data`=0, `rd_last`=0, `ovf_cnt`=0. Reset wins over `arm` and all other inputs.
- IDLE: nothing is captured and nothing is readable.
- `arm`=1 in any state:
  - clears `count`, pointers, word index, post counter and `ovf_cnt`;
  - sets the next state to ARMED;
  - the tuple sampled on that edge is not written;
  - any read in progress is abandoned.
- ARMED: every edge writes the sampled tuple at the write pointer.
  - If the buffer is full, the oldest entry is overwritten: the read pointer advances, `count` is unchanged and `ovf_cnt` increments.
  - Trigger condition: `trig_en`=0, or `pc`==`trig_pc`. On trigger the entry is written and counts as post-trigger entry 1.
  - The next state is CAPTURE, or STOPPED if `POST_TRIG`=1.
- CAPTURE: every edge writes with the same overwrite rule. The post counter increments; when it reaches `POST_TRIG` the next state is STOPPED. PC matches are ignored.
- STOPPED: no writes.
  - `rd_valid`=(`count`≠0).
  - Entries are read oldest-first. Word order within an entry: pc, instr, alu, mem.
  - `rd_last`=1 on the mem word.
- Read handshake: a word transfers on an edge with `rd_valid`&`rd_ready`, and the word index advances. The transfer of the mem word pops the entry: read pointer +1, `count`−1, word index back to 0.
- `rd_data`/`rd_last` are combinational from the storage array, read pointer and word index. Both are 0 when `rd_valid`=0. They are stable while `rd_valid`&!`rd_ready`.
- `rd_ready` is ignored outside STOPPED.
- Pointers wrap modulo `DEPTH`. `count` saturates at `DEPTH` and reaches `DEPTH` only via writes.

## Timing
- Capture latency 0: the tuple at edge N is stored at edge N and readable once STOPPED.
- The trigger is seen at edge T. STOPPED is entered at edge T+`POST_TRIG`−1, so `state`=3 from T+`POST_TRIG`−1 onward.
- The first `rd_valid` is in the cycle after entry to STOPPED.
- Throughput: one word per cycle with `rd_ready` held high; DEPTH entries drain in 4·`count` cycles.
- An `arm` pulse during CAPTURE restarts capture. The post-trigger history is lost, and the trigger must recur.

## Configuration
- `SC_TRACE_OVF_CNT_EN` defined:
  - `ovf_cnt` is a 16-bit counter of entries overwritten since the last arm or reset.
  - It saturates at 0xFFFF.
  - It is cleared by `arm`.
- `SC_TRACE_OVF_CNT_EN` undefined: the counter logic is absent and `ovf_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- Reset value check: hold `clrn`=0 for 2 edges with `arm`=1 → `state`=0, `count`=0, `rd_valid`=0, `rd_data`=0, `ovf_cnt`=0.
- Pre-trigger wrap (`DEPTH`=16, `POST_TRIG`=8):
  - Arm with `trig_en`=1, `trig_pc`=0x40. Drive pc 0x00,0x04,… one per edge.
  - Expected: trigger at 0x40 (entry 17); STOPPED after pc 0x5C; `count`=16.
  - First read entry pc=0x20; `ovf_cnt`=8 with macro, 0 without.
- Immediate trigger:
  - `trig_en`=0, `POST_TRIG`=1. Arm, then pc=0x100 at the next edge.
  - Expected: STOPPED at that edge; `count`=1.
  - Reads: words 0x100, instr, alu, mem; `rd_last`=1 only on the 4th; afterwards `rd_valid`=0.
- Backpressure:
  - In STOPPED with `count`=2, toggle `rd_ready` 1,0,0,1,…
  - Expected: `rd_data` holds while `rd_ready`=0; exactly 8 transfers; `count` decrements only on `rd_last` transfers.
- Arm mid-CAPTURE:
  - Assert `arm` 3 edges after the trigger.
  - Expected: `count`=0 and `state`=1 next cycle; the arm-edge tuple is absent; a later trigger recaptures correctly.
- Reset mid-read: `clrn`=0 during the 2nd word of an entry → all outputs return to reset values next cycle; `rd_valid`=0 until re-armed and stopped.

Source files
------------

// File: rtl/sc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sc_trace_buffer
// Purpose  : Post-trigger trace capture buffer for the single-cycle RISC-V
//            computer. Each clock it records the retired {pc, instr, alu, mem}
//            tuple into a rolling history. Once a PC trigger fires, it takes
//            POST_TRIG entries, counting the trigger entry, and then freezes.
//            The frozen history is read oldest-first, one 32-bit word per
//            transfer, over a valid/ready port.
// Ports    : clk, clrn (synchronous, active-low reset)
//            pc/instr/alu/mem : retired tuple, sampled every edge
//            arm              : restart capture (level, every edge)
//            trig_en/trig_pc  : PC-match trigger, or trigger on first sample
//            rd_valid/rd_ready/rd_data/rd_last : read port
//            state, count, ovf_cnt : status
// Options  : define SC_TRACE_OVF_CNT_EN to build the saturating 16-bit
//            overwrite counter; otherwise ovf_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sc_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic [31:0]              alu,
  input  logic [31:0]              mem,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_data,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_STOPPED = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [127:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_post;
  logic [1:0]      r_word;

  logic            w_trig;
  logic            w_wr;
  logic            w_xfer;
  logic            w_full;
  logic            w_rd_valid;
  logic [CW-1:0]   w_post_nxt;
  logic [127:0]    w_entry;
  logic [31:0]     w_word;

  assign w_trig     = !trig_en || (pc == trig_pc);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_post_nxt = r_post + 1'b1;
  assign w_rd_valid = (r_state == S_STOPPED) && (r_count != '0);

  // Next-state and per-edge actions. arm overrides every state; writes and
  // read transfers are mutually exclusive because they live in different
  // states.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_xfer      = 1'b0;
    if (arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          w_wr = 1'b1;
          if (w_trig) begin
            w_state_nxt = (POST_TRIG == 1) ? S_STOPPED : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          w_wr = 1'b1;
          if (w_post_nxt == CW'(POST_TRIG)) begin
            w_state_nxt = S_STOPPED;
          end
        end
        S_STOPPED: w_xfer = w_rd_valid && rd_ready;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage array has no reset; its contents are only visible while rd_valid.
  always_ff @(posedge clk) begin
    if (clrn && w_wr) begin
      r_mem[r_wr_ptr] <= {pc, instr, alu, mem};
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn || arm) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_post   <= '0;
      r_word   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        // When full, the oldest entry is overwritten, so the read side moves
        // with the write side and the count stays at DEPTH.
        if (w_full) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
        if (r_state == S_ARMED && w_trig) begin
          r_post <= CW'(1);
        end else if (r_state == S_CAPTURE) begin
          r_post <= w_post_nxt;
        end
      end
      if (w_xfer) begin
        if (r_word == 2'd3) begin
          r_word   <= 2'd0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count  <= r_count - 1'b1;
        end else begin
          r_word <= r_word + 2'd1;
        end
      end
    end
  end

  assign w_entry = r_mem[r_rd_ptr];

  always_comb begin
    w_word = 32'd0;
    case (r_word)
      2'd0:    w_word = w_entry[127:96];
      2'd1:    w_word = w_entry[95:64];
      2'd2:    w_word = w_entry[63:32];
      default: w_word = w_entry[31:0];
    endcase
  end

  assign rd_valid = w_rd_valid;
  assign rd_data  = w_rd_valid ? w_word : 32'd0;
  assign rd_last  = w_rd_valid && (r_word == 2'd3);
  assign state    = r_state;
  assign count    = r_count;

`ifdef SC_TRACE_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (!clrn || arm) begin
      r_ovf_cnt <= 16'd0;
    end else if (w_wr && w_full && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  assign ovf_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_trace_buffer
// Purpose  : Directed self-checking bench for sc_trace_buffer. u_dut_m uses
//            DEPTH=16/POST_TRIG=8 and u_dut_s uses DEPTH=16/POST_TRIG=1. Both
//            share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_trace_buffer;

  logic        clk = 1'b0;
  logic        clrn, arm, trig_en, rd_ready;
  logic [31:0] pc, instr, alu, mem, trig_pc;

  logic        m_rd_valid, m_rd_last, s_rd_valid, s_rd_last;
  logic [31:0] m_rd_data, s_rd_data;
  logic [1:0]  m_state, s_state;
  logic [4:0]  m_count, s_count;
  logic [15:0] m_ovf, s_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sc_trace_buffer #(.DEPTH(16), .POST_TRIG(8)) u_dut_m (
    .clk(clk), .clrn(clrn), .pc(pc), .instr(instr), .alu(alu), .mem(mem),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(m_rd_valid), .rd_ready(rd_ready), .rd_data(m_rd_data),
    .rd_last(m_rd_last), .state(m_state), .count(m_count), .ovf_cnt(m_ovf)
  );

  sc_trace_buffer #(.DEPTH(16), .POST_TRIG(1)) u_dut_s (
    .clk(clk), .clrn(clrn), .pc(pc), .instr(instr), .alu(alu), .mem(mem),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(s_rd_valid), .rd_ready(rd_ready), .rd_data(s_rd_data),
    .rd_last(s_rd_last), .state(s_state), .count(s_count), .ovf_cnt(s_ovf)
  );

  // The other tuple fields are derived from pc so that expected words can be
  // recomputed from the pc alone.
  function automatic logic [31:0] exp_word(input logic [31:0] p, input int w);
    case (w)
      0:       return p;
      1:       return p ^ 32'h13A5_0000;
      2:       return p + 32'h0000_1000;
      default: return ~p;
    endcase
  endfunction

  task automatic set_pc(input logic [31:0] p);
    pc    = p;
    instr = exp_word(p, 1);
    alu   = exp_word(p, 2);
    mem   = exp_word(p, 3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; arm = 1'b1; trig_en = 1'b1; trig_pc = 32'h0; rd_ready = 1'b1;
    set_pc(32'h0);
    step(); step();
    checks++; if (m_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", m_state); end
    checks++; if (m_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", m_count); end
    checks++; if (m_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", m_rd_valid); end
    checks++; if (m_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", m_rd_data); end
    checks++; if (m_ovf !== 16'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", m_ovf); end
    checks++; if (s_state !== 2'd0) begin errors++; $display("FAIL reset_state_s: got %0d expected 0", s_state); end
    rd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_ovf;
`ifdef SC_TRACE_OVF_CNT_EN
    exp_ovf = 16'd8;
`else
    exp_ovf = 16'd0;
`endif
    clrn = 1'b1; arm = 1'b1; trig_en = 1'b1; trig_pc = 32'h40;
    step();
    arm = 1'b0;
    checks++; if (m_state !== 2'd1 || m_count !== 5'd0) begin errors++; $display("FAIL wrap_armed: got state %0d count %0d expected 1 0", m_state, m_count); end
    for (int i = 0; i < 24; i++) begin
      set_pc(32'(i * 4));
      step();
      if (i == 22) begin
        checks++; if (m_state !== 2'd2) begin errors++; $display("FAIL wrap_capture: got %0d expected 2", m_state); end
      end
    end
    checks++; if (m_state !== 2'd3) begin errors++; $display("FAIL wrap_stopped: got %0d expected 3", m_state); end
    checks++; if (m_count !== 5'd16) begin errors++; $display("FAIL wrap_count: got %0d expected 16", m_count); end
    checks++; if (m_ovf !== exp_ovf) begin errors++; $display("FAIL wrap_ovf: got %0d expected %0d", m_ovf, exp_ovf); end
    checks++; if (m_rd_valid !== 1'b1) begin errors++; $display("FAIL wrap_rd_valid: got %0b expected 1", m_rd_valid); end
    rd_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin
      logic [31:0] e;
      e = exp_word(32'h20 + 32'((n / 4) * 4), n % 4);
      checks++;
      if (m_rd_data !== e || m_rd_last !== (n % 4 == 3)) begin
        errors++; $display("FAIL wrap_drain[%0d]: got %0h last %0b expected %0h last %0b", n, m_rd_data, m_rd_last, e, (n % 4 == 3));
      end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (m_rd_valid !== 1'b0 || m_count !== 5'd0) begin errors++; $display("FAIL wrap_empty: got valid %0b count %0d expected 0 0", m_rd_valid, m_count); end
  endtask

  task automatic test_immediate();
    trig_en = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0;
    set_pc(32'h100);
    step();
    checks++; if (s_state !== 2'd3 || s_count !== 5'd1) begin errors++; $display("FAIL imm_stop: got state %0d count %0d expected 3 1", s_state, s_count); end
    rd_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (s_rd_valid !== 1'b1 || s_rd_data !== exp_word(32'h100, w) || s_rd_last !== (w == 3)) begin
        errors++; $display("FAIL imm_word[%0d]: got %0h last %0b expected %0h last %0b", w, s_rd_data, s_rd_last, exp_word(32'h100, w), (w == 3));
      end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (s_rd_valid !== 1'b0) begin errors++; $display("FAIL imm_empty: got %0b expected 0", s_rd_valid); end
  endtask

  task automatic test_backpressure();
    int wi;
    logic rdy;
    trig_en = 1'b1; trig_pc = 32'h204; arm = 1'b1;
    step();
    arm = 1'b0;
    set_pc(32'h200); step();
    set_pc(32'h204); step();
    checks++; if (s_state !== 2'd3 || s_count !== 5'd2) begin errors++; $display("FAIL bp_stop: got state %0d count %0d expected 3 2", s_state, s_count); end
    wi = 0;
    for (int k = 0; k < 40 && wi < 8; k++) begin
      logic [31:0] e;
      rdy = (k % 4 == 0) || (k % 4 == 3);
      rd_ready = rdy;
      e = exp_word(32'h200 + 32'((wi / 4) * 4), wi % 4);
      checks++;
      if (s_rd_valid !== 1'b1 || s_rd_data !== e || s_rd_last !== (wi % 4 == 3)) begin
        errors++; $display("FAIL bp_word[%0d]: got valid %0b data %0h last %0b expected 1 %0h %0b", k, s_rd_valid, s_rd_data, s_rd_last, e, (wi % 4 == 3));
      end
      step();
      if (rdy) wi++;
      checks++;
      if (s_count !== 5'(2 - wi / 4)) begin errors++; $display("FAIL bp_count[%0d]: got %0d expected %0d", k, s_count, 2 - wi / 4); end
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++; if (s_rd_valid !== 1'b0 || s_count !== 5'd0) begin errors++; $display("FAIL bp_done: got valid %0b count %0d expected 0 0", s_rd_valid, s_count); end
  endtask

  task automatic test_arm_mid_capture();
    trig_en = 1'b1; trig_pc = 32'h300; arm = 1'b1;
    step();
    arm = 1'b0;
    set_pc(32'h2F8); step();
    set_pc(32'h2FC); step();
    set_pc(32'h300); step();
    set_pc(32'h304); step();
    set_pc(32'h308); step();
    checks++; if (m_state !== 2'd2) begin errors++; $display("FAIL amc_capture: got %0d expected 2", m_state); end
    arm = 1'b1; set_pc(32'h30C); step();
    arm = 1'b0;
    checks++; if (m_state !== 2'd1 || m_count !== 5'd0) begin errors++; $display("FAIL amc_rearm: got state %0d count %0d expected 1 0", m_state, m_count); end
    for (int k = 0; k < 10; k++) begin
      set_pc(k < 2 ? 32'h310 + 32'(4 * k) : 32'h300 + 32'(4 * (k - 2)));
      step();
      if (k == 8) begin
        checks++; if (m_state !== 2'd2) begin errors++; $display("FAIL amc_recapture: got %0d expected 2", m_state); end
      end
    end
    checks++; if (m_state !== 2'd3 || m_count !== 5'd10) begin errors++; $display("FAIL amc_stop: got state %0d count %0d expected 3 10", m_state, m_count); end
    rd_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (m_rd_data !== exp_word(32'h310, w)) begin errors++; $display("FAIL amc_first[%0d]: got %0h expected %0h", w, m_rd_data, exp_word(32'h310, w)); end
      step();
    end
    checks++; if (m_rd_data !== 32'h314) begin errors++; $display("FAIL amc_second: got %0h expected 314", m_rd_data); end
    step();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    checks++; if (m_rd_data !== exp_word(32'h314, 1)) begin errors++; $display("FAIL rmr_word2: got %0h expected %0h", m_rd_data, exp_word(32'h314, 1)); end
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    checks++; if (m_state !== 2'd0 || m_count !== 5'd0) begin errors++; $display("FAIL rmr_state: got state %0d count %0d expected 0 0", m_state, m_count); end
    checks++;
    if (m_rd_valid !== 1'b0 || m_rd_data !== 32'd0 || m_rd_last !== 1'b0 || m_ovf !== 16'd0) begin
      errors++; $display("FAIL rmr_outputs: got valid %0b data %0h last %0b ovf %0d expected 0 0 0 0", m_rd_valid, m_rd_data, m_rd_last, m_ovf);
    end
    step(); step(); step();
    checks++; if (m_rd_valid !== 1'b0 || m_state !== 2'd0) begin errors++; $display("FAIL rmr_idle: got valid %0b state %0d expected 0 0", m_rd_valid, m_state); end
    trig_en = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_pc(32'h400 + 32'(4 * k));
      step();
    end
    checks++; if (m_state !== 2'd3 || m_count !== 5'd8) begin errors++; $display("FAIL rmr_restop: got state %0d count %0d expected 3 8", m_state, m_count); end
    checks++; if (m_rd_valid !== 1'b1 || m_rd_data !== 32'h400) begin errors++; $display("FAIL rmr_read: got valid %0b data %0h expected 1 400", m_rd_valid, m_rd_data); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_immediate();
    test_backpressure();
    test_arm_mid_capture();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
